// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable data width, stop length and parity.
// Deserialises an idle-high line LSB first and reports parity and framing errors.
module uart_rx_param #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            parity_err,
    output logic            frame_err,
    output logic            busy
);

    localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = $clog2(DBIT) + 1;

    localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);
    localparam logic           HAS_PAR = (PARITY_EN != 0);
    localparam logic           ODD     = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rxs;
    logic [S_W-1:0]  s;
    logic [N_W-1:0]  n;
    logic [DBIT-1:0] buffer;
    logic            p;

    // Two-flop synchroniser; resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign busy = (state != IDLE);

    // NOTE: all state uses non-blocking assignments so every branch reads the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift buffer is a small register, not a memory, so it is cleared with the rest.
            state      <= IDLE;
            s          <= '0;
            n          <= '0;
            buffer     <= '0;
            p          <= 1'b0;
            d_out      <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        s     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == S_HALF) begin
                            // Still low at the half-bit point: a real start bit, not a glitch.
                            if (!rxs) begin
                                state <= DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            s      <= '0;
                            buffer <= {rxs, buffer[DBIT-1:1]};
                            if (n == N_LAST) begin
                                state <= HAS_PAR ? PARITY : STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            p     <= rxs;
                            s     <= '0;
                            state <= STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == S_STOP) begin
                            d_out      <= buffer;
                            rx_done    <= 1'b1;
                            frame_err  <= ~rxs;
                            parity_err <= HAS_PAR & (p != (^buffer ^ ODD));
                            s          <= '0;
                            state      <= IDLE;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three parameterisations driven by hand-built frames
// with expected words and error flags worked out by hand.
module tb_uart_rx_param;

    logic clk = 1'b0;
    logic reset;
    logic s_tick1;
    logic s_tick3;
    logic rx_def, rx_par, rx_d7;

    logic [7:0] d_def, d_par;
    logic [6:0] d_d7;
    logic done_def, pe_def, fe_def, busy_def;
    logic done_par, pe_par, fe_par, busy_par;
    logic done_d7, pe_d7, fe_d7, busy_d7;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_param u_def (
        .clk(clk), .reset(reset), .s_tick(s_tick1), .rx(rx_def),
        .d_out(d_def), .rx_done(done_def), .parity_err(pe_def), .frame_err(fe_def), .busy(busy_def)
    );

    uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk(clk), .reset(reset), .s_tick(s_tick1), .rx(rx_par),
        .d_out(d_par), .rx_done(done_par), .parity_err(pe_par), .frame_err(fe_par), .busy(busy_par)
    );

    uart_rx_param #(.DBIT(7), .SB_TICK(32)) u_d7 (
        .clk(clk), .reset(reset), .s_tick(s_tick3), .rx(rx_d7),
        .d_out(d_d7), .rx_done(done_d7), .parity_err(pe_d7), .frame_err(fe_d7), .busy(busy_d7)
    );

    // Pulse monitors sample 1 time unit after the active edge.
    int cnt_def = 0, cnt_par = 0, cnt_d7 = 0, busy_cnt_def = 0;
    logic [7:0] last_d_def, last_d_par;
    logic [6:0] cap_d7 [0:7];

    always @(posedge clk) begin
        #1;
        if (done_def) begin
            last_d_def = d_def;
            cnt_def++;
        end
        if (done_par) begin
            last_d_par = d_par;
            cnt_par++;
        end
        if (done_d7) begin
            if (cnt_d7 < 8) cap_d7[cnt_d7] = d_d7;
            cnt_d7++;
        end
        if (busy_def) busy_cnt_def++;
    end

    initial begin
        int ph;
        ph = 0;
        s_tick3 = 1'b0;
        forever begin
            @(negedge clk);
            ph = (ph == 2) ? 0 : ph + 1;
            s_tick3 = (ph == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rx(input int inst, input logic v);
        case (inst)
            0:       rx_def = v;
            1:       rx_par = v;
            default: rx_d7  = v;
        endcase
    endtask

    function automatic int get_cnt(input int inst);
        case (inst)
            0:       return cnt_def;
            1:       return cnt_par;
            default: return cnt_d7;
        endcase
    endfunction

    task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par_bit, input logic stop_val,
                              input int bit_clk, input int stop_clk);
        set_rx(inst, 1'b0);
        wait_clk(bit_clk);
        for (int i = 0; i < nbits; i++) begin
            set_rx(inst, data[i]);
            wait_clk(bit_clk);
        end
        if (has_par) begin
            set_rx(inst, par_bit);
            wait_clk(bit_clk);
        end
        set_rx(inst, stop_val);
        wait_clk(stop_clk);
        set_rx(inst, 1'b1);
    endtask

    task automatic wait_count(input int inst, input int target, input int budget, input string name);
        int k;
        k = 0;
        while (get_cnt(inst) < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (get_cnt(inst) < target) begin
            errors++;
            $display("FAIL %s_timeout: rx_done count %0d required %0d", name, get_cnt(inst), target);
        end
    endtask

    task automatic test_reset();
        wait_clk(3);
        checks++;
        if ({d_def, done_def, pe_def, fe_def, busy_def} !== 12'h000) begin
            errors++;
            $display("FAIL reset_def: outputs %h required 000", {d_def, done_def, pe_def, fe_def, busy_def});
        end
        checks++;
        if ({d_par, done_par, pe_par, fe_par, busy_par} !== 12'h000) begin
            errors++;
            $display("FAIL reset_par: outputs %h required 000", {d_par, done_par, pe_par, fe_par, busy_par});
        end
        checks++;
        if ({d_d7, done_d7, pe_d7, fe_d7, busy_d7} !== 11'h000) begin
            errors++;
            $display("FAIL reset_d7: outputs %h required 000", {d_d7, done_d7, pe_d7, fe_d7, busy_d7});
        end
        reset = 1'b0;
        wait_clk(5);
    endtask

    task automatic test_basic();
        int c0;
        c0 = cnt_def;
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 16, 16);
        wait_count(0, c0 + 1, 200, "basic");
        wait_clk(20);
        checks++;
        if (cnt_def !== c0 + 1) begin
            errors++;
            $display("FAIL basic_pulses: got %0d required %0d", cnt_def - c0, 1);
        end
        checks++;
        if (last_d_def !== 8'hA5) begin
            errors++;
            $display("FAIL basic_data: got %h required a5", last_d_def);
        end
        checks++;
        if ({pe_def, fe_def, busy_def} !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags: pe/fe/busy %b required 000", {pe_def, fe_def, busy_def});
        end
    endtask

    task automatic test_glitch();
        int c0, b0;
        c0 = cnt_def;
        b0 = busy_cnt_def;
        set_rx(0, 1'b0);
        wait_clk(4);
        set_rx(0, 1'b1);
        wait_clk(30);
        checks++;
        if (busy_cnt_def == b0) begin
            errors++;
            $display("FAIL glitch_busy_rise: busy never went high");
        end
        checks++;
        if (busy_def !== 1'b0 || cnt_def !== c0) begin
            errors++;
            $display("FAIL glitch_abort: busy %b pulses %0d required busy 0 pulses 0", busy_def, cnt_def - c0);
        end
        checks++;
        if (d_def !== 8'hA5) begin
            errors++;
            $display("FAIL glitch_hold: d_out %h required a5", d_def);
        end
    endtask

    task automatic test_parity();
        int c0;
        c0 = cnt_par;
        send_frame(1, 9'h003, 8, 1'b1, 1'b0, 1'b1, 16, 16);
        wait_count(1, c0 + 1, 200, "parity_good");
        wait_clk(20);
        checks++;
        if (last_d_par !== 8'h03 || pe_par !== 1'b0 || fe_par !== 1'b0) begin
            errors++;
            $display("FAIL parity_good: d %h pe %b fe %b required 03 0 0", last_d_par, pe_par, fe_par);
        end
        send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1'b1, 16, 16);
        wait_count(1, c0 + 2, 200, "parity_bad");
        wait_clk(20);
        checks++;
        if (d_par !== 8'h03 || pe_par !== 1'b1 || fe_par !== 1'b0) begin
            errors++;
            $display("FAIL parity_bad: d %h pe %b fe %b required 03 1 0", d_par, pe_par, fe_par);
        end
        checks++;
        if (cnt_par !== c0 + 2) begin
            errors++;
            $display("FAIL parity_pulses: got %0d required 2", cnt_par - c0);
        end
    endtask

    task automatic test_frame_err();
        int c0;
        c0 = cnt_def;
        send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1'b0, 16, 12);
        wait_count(0, c0 + 1, 200, "frame_err");
        wait_clk(40);
        checks++;
        if (d_def !== 8'h00 || fe_def !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_set: d %h fe %b required 00 1", d_def, fe_def);
        end
        checks++;
        if (cnt_def !== c0 + 1 || busy_def !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_recover: pulses %0d busy %b required 1 0", cnt_def - c0, busy_def);
        end
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 16, 16);
        wait_count(0, c0 + 2, 200, "frame_clear");
        wait_clk(20);
        checks++;
        if (d_def !== 8'h5A || fe_def !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_clear: d %h fe %b required 5a 0", d_def, fe_def);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cnt_d7;
        send_frame(2, 9'h07F, 7, 1'b0, 1'b0, 1'b1, 48, 96);
        send_frame(2, 9'h001, 7, 1'b0, 1'b0, 1'b1, 48, 96);
        wait_count(2, c0 + 2, 600, "b2b");
        wait_clk(100);
        checks++;
        if (cnt_d7 !== c0 + 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d required 2", cnt_d7 - c0);
        end
        checks++;
        if (cap_d7[0] !== 7'h7F || cap_d7[1] !== 7'h01) begin
            errors++;
            $display("FAIL b2b_data: got %h %h required 7f 01", cap_d7[0], cap_d7[1]);
        end
        checks++;
        if (d_d7 !== 7'h01 || fe_d7 !== 1'b0 || pe_d7 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final: d %h fe %b pe %b required 01 0 0", d_d7, fe_d7, pe_d7);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        c0 = cnt_def;
        set_rx(0, 1'b0);
        wait_clk(16);
        set_rx(0, 1'b1);
        wait_clk(16);
        set_rx(0, 1'b1);
        wait_clk(16);
        set_rx(0, 1'b0);
        wait_clk(24);
        checks++;
        if (busy_def !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy: busy %b required 1", busy_def);
        end
        reset = 1'b1;
        set_rx(0, 1'b1);
        wait_clk(1);
        checks++;
        if ({d_def, done_def, pe_def, fe_def, busy_def} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_clear: outputs %h required 000", {d_def, done_def, pe_def, fe_def, busy_def});
        end
        reset = 1'b0;
        wait_clk(40);
        checks++;
        if (cnt_def !== c0) begin
            errors++;
            $display("FAIL reset_mid_no_done: pulses %0d required 0", cnt_def - c0);
        end
        send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 16, 16);
        wait_count(0, c0 + 1, 200, "after_reset");
        wait_clk(20);
        checks++;
        if (d_def !== 8'hC3 || fe_def !== 1'b0 || cnt_def !== c0 + 1) begin
            errors++;
            $display("FAIL after_reset: d %h fe %b pulses %0d required c3 0 1", d_def, fe_def, cnt_def - c0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        s_tick1 = 1'b1;
        rx_def  = 1'b1;
        rx_par  = 1'b1;
        rx_d7   = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
